// File: rtl/ppi_frame_gen.sv
// PPI frame generator: emits SYNC header, payload words from an internal RAM and an XOR
// checksum as clocked word slots, optionally repeating frames separated by idle gap slots.
module ppi_frame_gen #(
  parameter int unsigned DW         = 16,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned NFS        = 3,
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [DW-1:0] START_WORD = DW'(16'hFFFF),
  parameter int unsigned GAP_SLOTS  = 2,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en_i,
  input  logic [AW-1:0]  wr_addr_i,
  input  logic [DW-1:0]  wr_data_i,
  input  logic           start_i,
  input  logic           mode_cont_i,
  input  logic [AW-1:0]  len_i,
  input  logic [NFS-1:0] fs_mask_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [15:0]    frame_cnt_o,
  output logic           clk_ppi_o,
  output logic [NFS-1:0] fs_o,
  output logic [DW-1:0]  data_ppi_o
);

  localparam int unsigned DVW = $clog2(CLK_DIV);
  localparam int unsigned GW  = $clog2(GAP_SLOTS + 1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(CLK_DIV - 1);
  localparam logic [DVW-1:0] DIV_HALF = DVW'(CLK_DIV / 2);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_SLOTS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_SEND, ST_CRC, ST_GAP} state_e;

  state_e         state_q, state_d;
  logic [DVW-1:0] div_q, div_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [AW-1:0]  len_q, len_d;
  logic [NFS-1:0] mask_q, mask_d;
  logic [DW-1:0]  csum_q, csum_d;
  logic           cont_q, cont_d;
  logic           crc_end_q, crc_end_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [15:0]    fc_q, fc_d;
  logic           clk_ppi_q, clk_ppi_d;
  logic [NFS-1:0] fs_q, fs_d;
  logic [DW-1:0]  data_q, data_d;

  logic [DW-1:0]  mem [DEPTH];
  logic           slot_end;
  logic           idle_free;

  assign slot_end  = (div_q == DIV_LAST);
  assign idle_free = (state_q == ST_IDLE) && !busy_q;

  // Payload RAM: writable only while fully idle, never reset.
  always_ff @(posedge clk) begin
    if (wr_en_i && idle_free) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Sequencer runs one cycle ahead of the registered line outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    len_d     = len_q;
    mask_d    = mask_q;
    csum_d    = csum_q;
    cont_d    = cont_q;
    crc_end_d = 1'b0;
    busy_d    = (state_q != ST_IDLE);
    done_d    = crc_end_q && !cont_q;
    fc_d      = crc_end_q ? fc_q + 16'd1 : fc_q;
    clk_ppi_d = 1'b0;
    fs_d      = '0;
    data_d    = '0;
    div_d     = (state_q == ST_IDLE || slot_end) ? '0 : div_q + DVW'(1);

    case (state_q)
      ST_IDLE: begin
        if (start_i && idle_free) begin
          state_d = ST_SYNC;
          len_d   = len_i;
          mask_d  = fs_mask_i;
          fc_d    = 16'd0;
        end
      end
      ST_SYNC: begin
        clk_ppi_d = (div_q >= DIV_HALF);
        fs_d      = mask_q;
        data_d    = START_WORD;
        csum_d    = START_WORD;
        if (slot_end) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        clk_ppi_d = (div_q >= DIV_HALF);
        data_d    = mem[idx_q];
        if (div_q == '0) begin
          csum_d = csum_q ^ mem[idx_q];
        end
        if (slot_end) begin
          if (idx_q == len_q) begin
            state_d = ST_CRC;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      ST_CRC: begin
        clk_ppi_d = (div_q >= DIV_HALF);
        data_d    = csum_q;
        if (slot_end) begin
          crc_end_d = 1'b1;
          cont_d    = mode_cont_i;
          gap_d     = '0;
          state_d   = mode_cont_i ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (slot_end) begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_SYNC;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      len_q     <= '0;
      mask_q    <= '0;
      csum_q    <= '0;
      cont_q    <= 1'b0;
      crc_end_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fc_q      <= '0;
      clk_ppi_q <= 1'b0;
      fs_q      <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      len_q     <= len_d;
      mask_q    <= mask_d;
      csum_q    <= csum_d;
      cont_q    <= cont_d;
      crc_end_q <= crc_end_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fc_q      <= fc_d;
      clk_ppi_q <= clk_ppi_d;
      fs_q      <= fs_d;
      data_q    <= data_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_cnt_o = fc_q;
  assign clk_ppi_o   = clk_ppi_q;
  assign fs_o        = fs_q;
  assign data_ppi_o  = data_q;

endmodule
